// File: rtl/occupancy_counter_if.sv
// Sensor and status bundle between the gate synchronisers, the occupancy
// counter and the display/gate-control logic.
interface occupancy_counter_if #(
  parameter int W = 5
);
  logic         inc;
  logic         dec;
  logic         clr_err;
  logic [W-1:0] out;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         ovf_err;
  logic         unf_err;
  logic [W-1:0] peak;

  modport master (
    output inc, dec, clr_err,
    input  out, full, empty, almost_full, ovf_err, unf_err, peak
  );

  modport slave (
    input  inc, dec, clr_err,
    output out, full, empty, almost_full, ovf_err, unf_err, peak
  );
endinterface

// File: rtl/occupancy_counter.sv
// Parking-lot occupancy counter: edge-detected entry/exit sensors, saturating
// count, occupancy flags, sticky over/underflow errors and a high-water mark.
module occupancy_counter #(
  parameter int CAPACITY    = 25,
  parameter int ALMOST_FULL = 23
) (
  input logic               clk,
  input logic               rst,
  occupancy_counter_if.slave bus
);
  localparam int W = $clog2(CAPACITY + 1);
  localparam logic [W-1:0] CAP = W'(CAPACITY);
  localparam logic [W-1:0] AF  = W'(ALMOST_FULL);

  logic         inc_q, dec_q;
  logic         inc_ev, dec_ev;
  logic [W-1:0] count, count_nxt;
  logic [W-1:0] peak_q;
  logic         ovf_q, unf_q;
  logic         ovf_set, unf_set;

  // Sensor history is loaded even during reset so that a sensor held high
  // across reset release is not seen as a fresh arrival.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values of its neighbours.
    inc_q <= bus.inc;
    dec_q <= bus.dec;
  end

  assign inc_ev = bus.inc & ~inc_q;
  assign dec_ev = bus.dec & ~dec_q;

  always_comb begin
    // NOTE: defaults first so that every path assigns every output and no
    // latch is inferred.
    count_nxt = count;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    unique case ({inc_ev, dec_ev})
      2'b10: begin
        if (count < CAP) count_nxt = count + 1'b1;
        else             ovf_set   = 1'b1;
      end
      2'b01: begin
        if (count != '0) count_nxt = count - 1'b1;
        else             unf_set   = 1'b1;
      end
      default: ;  // simultaneous entry and exit cancel out; idle holds
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      peak_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      count <= count_nxt;
      if (bus.clr_err) begin
        // Post-update count keeps peak >= out even if an event lands on the
        // clearing edge; without an event it equals the current count.
        peak_q <= count_nxt;
        ovf_q  <= 1'b0;
        unf_q  <= 1'b0;
      end else begin
        if (count_nxt > peak_q) peak_q <= count_nxt;
        ovf_q <= ovf_q | ovf_set;
        unf_q <= unf_q | unf_set;
      end
    end
  end

  assign bus.out         = count;
  assign bus.peak        = peak_q;
  assign bus.full        = (count == CAP);
  assign bus.empty       = (count == '0);
  assign bus.almost_full = (count >= AF);
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;
endmodule

// File: doc/occupancy_counter.md
Name: occupancy_counter

Overview:
Parametrised occupancy counter for the parking lot meter, counting cars between 0 and CAPACITY.
- Entry/exit sensors are level inputs, edge-detected internally, so a car held on a sensor counts once.
- Adds full/empty/almost-full flags, saturating behaviour, net-zero handling of simultaneous entry and exit, sticky error flags and a high-water mark.
- Sits between the gate sensor synchronisers and the display/gate-control logic.

Parameters:
CAPACITY, 25, maximum occupancy; legal range 1..255.
ALMOST_FULL, 23, threshold for almost_full; must satisfy ALMOST_FULL <= CAPACITY.
W, $clog2(CAPACITY+1), derived localparam giving the count width (5 for the defaults); not overridable.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
inc  input  1  entry sensor level, already synchronised to clk.
dec  input  1  exit sensor level, already synchronised to clk.
clr_err  input  1  synchronous clear of the sticky error flags and the peak register.
out  output  W  current occupancy.
full  output  1  out == CAPACITY.
empty  output  1  out == 0.
almost_full  output  1  out >= ALMOST_FULL.
ovf_err  output  1  sticky: an entry event arrived while full.
unf_err  output  1  sticky: an exit event arrived while empty.
peak  output  W  highest out value since reset or clr_err.

Behaviour:
- Reset (rst=1 at posedge): out=0, peak=0, ovf_err=0, unf_err=0.
  - inc_q/dec_q are loaded with the current inc/dec, so a sensor held high through reset does not count when reset releases.
  - Flags after reset: empty=1, full=0, almost_full=0 (almost_full=1 if ALMOST_FULL=0).
  - rst overrides all other inputs, including mid-event.
- Edge detect: inc_ev = inc & ~inc_q; dec_ev = dec & ~dec_q. inc_q/dec_q register inc/dec every cycle.
- Count update at the posedge where the event is sampled; out changes one edge after the sensor goes high. Zero-latency combinational path from sensor to count is forbidden.
- Next-count rules:
  - inc_ev & ~dec_ev: out+1 if out < CAPACITY; else hold and set ovf_err.
  - dec_ev & ~inc_ev: out-1 if out > 0; else hold and set unf_err.
  - inc_ev & dec_ev: net zero, out holds, no error set (including at 0 and at CAPACITY).
  - Neither event: hold.
- No wrap-around: saturate at 0 and at CAPACITY.
- full, empty and almost_full are combinational decodes of the registered out; they are glitch-free relative to clk.
- peak:
  - Registered; peak <= max(peak, next out) on the same edge that out updates, so peak >= out always.
  - clr_err: peak <= current out.
- Sticky errors:
  - Held until rst or clr_err.
  - clr_err has priority over a same-cycle set: errors read 0 after that edge.
  - A new error in the next cycle sets them again.
- Counting and clearing are independent: clr_err does not alter out.
- States: the count register is the state (0..CAPACITY). Values above CAPACITY are unreachable; if forced, the next inc_ev holds and sets ovf_err, and dec_ev decrements.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with inc held high, release with inc still high -> out=0 and no count.
- Held sensor: inc high for 5 cycles, then low, repeated 3 times -> out=3; dec pulse -> out=2, peak=3.
- Fill to capacity: 25 inc pulses -> out=25, full=1, almost_full=1 from out=23. A 26th pulse -> out=25, ovf_err=1. clr_err -> ovf_err=0, peak=25.
- Underflow: from out=0, dec pulse -> out=0, unf_err=1, empty=1. Then inc pulse -> out=1, unf_err still 1.
- Simultaneous: at out=25 (and again at out=0), inc and dec rising in the same cycle -> out unchanged, no error.
- Reset mid-operation: out=12, assert rst in the same cycle as an inc edge -> out=0, peak=0, errors=0. Re-run with CAPACITY=7, ALMOST_FULL=5 -> W=3, saturation at 7, almost_full at 5.
